xpb_reduce_acc: RTL and testbench

XPB_REDUCE_ACC -- requirements
Module: xpb_reduce_acc

---
 rtl/xpb_reduce_acc.sv | 113 +++++++++++
 tb/tb_xpb_reduce_acc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_reduce_acc.sv
// Fixed-latency XPB reduction accumulator: walks the 5-bit upper digits through an external
// registered lookup table and sums every returned term onto the lower product word.
module xpb_reduce_acc #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 1024,
    parameter int ACC_W      = DATA_W + 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_DIGITS*5-1:0] upper_in,
    input  logic [DATA_W-1:0]       lower_in,
    output logic [4:0]              lut_idx,
    input  logic [DATA_W-1:0]       lut_data,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        result
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int UP_W  = NUM_DIGITS * 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [UP_W-1:0]   digits_reg;
    logic [4:0]        lut_idx_reg;
    logic              idx_vld_reg;
    logic              data_vld_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  result_reg;
    logic              accept;
    logic              last_digit;

    // A start is taken whenever the block is not busy, including the DONE cycle.
    assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_digit = (cnt_reg == CNT_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (last_digit) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = accept ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // data_vld_reg marks that lut_data belongs to the index presented last cycle.
    always_comb begin
        acc_next = acc_reg;
        if (data_vld_reg) begin
            acc_next = acc_reg + ACC_W'(lut_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            digits_reg   <= '0;
            lut_idx_reg  <= '0;
            idx_vld_reg  <= 1'b0;
            data_vld_reg <= 1'b0;
            acc_reg      <= '0;
            result_reg   <= '0;
        end else begin
            data_vld_reg <= idx_vld_reg;
            acc_reg      <= acc_next;
            if (accept) begin
                // Digit 0 goes out straight from the input; the rest shift down from digits_reg.
                digits_reg  <= upper_in >> 5;
                lut_idx_reg <= upper_in[4:0];
                idx_vld_reg <= 1'b1;
                cnt_reg     <= '0;
                acc_reg     <= ACC_W'(lower_in);
            end else if ((state_reg == ISSUE) && !last_digit) begin
                digits_reg  <= digits_reg >> 5;
                lut_idx_reg <= digits_reg[4:0];
                idx_vld_reg <= 1'b1;
                cnt_reg     <= cnt_reg + CNT_W'(1);
            end else begin
                lut_idx_reg <= '0;
                idx_vld_reg <= 1'b0;
            end
            if (state_reg == DRAIN) begin
                result_reg <= acc_next;
            end
        end
    end

    assign lut_idx = lut_idx_reg;
    assign busy    = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign done    = (state_reg == DONE);
    assign result  = result_reg;

endmodule

// File: tb/tb_xpb_reduce_acc.sv
// Scoreboarded random bench for xpb_reduce_acc against a table-lookup-and-sum reference.
module tb_xpb_reduce_acc;

    localparam int NUM_DIGITS = 8;
    localparam int DATA_W     = 1024;
    localparam int ACC_W      = DATA_W + 8;
    localparam int UP_W       = NUM_DIGITS * 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [UP_W-1:0]   upper_in = '0;
    logic [DATA_W-1:0] lower_in = '0;
    logic [4:0]        lut_idx;
    logic [DATA_W-1:0] lut_data = '0;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;

    xpb_reduce_acc #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .upper_in(upper_in), .lower_in(lower_in),
        .lut_idx(lut_idx), .lut_data(lut_data), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // External table stub: one-cycle registered read of a bench-owned table.
    logic [DATA_W-1:0] lut_tab [32];
    always @(posedge clk) lut_data <= lut_tab[lut_idx];

    typedef struct {
        logic [UP_W-1:0]  upper;
        logic [ACC_W-1:0] exp;
        int               acc_cyc;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [ACC_W-1:0] model(input logic [UP_W-1:0] up, input logic [DATA_W-1:0] lo);
        logic [ACC_W-1:0] s;
        s = ACC_W'(lo);
        for (int i = 0; i < NUM_DIGITS; i++) s = s + ACC_W'(lut_tab[up[5*i +: 5]]);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Acceptance: a start seen with busy low at a clock edge opens a transaction.
    always @(posedge clk) begin
        txn_t t;
        cyc = cyc + 1;
        if (!rst && start && !busy) begin
            t.upper   = upper_in;
            t.exp     = model(upper_in, lower_in);
            t.acc_cyc = cyc;
            q.push_back(t);
        end
    end

    // Monitor: lut_idx ordering, fixed latency and result of the oldest open transaction.
    always @(negedge clk) begin
        int rel;
        if (!rst) begin
            if (q.size() == 0) begin
                chk("idle_lut_idx", ACC_W'(lut_idx), '0);
                if (done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
                end
            end else begin
                rel = cyc - q[0].acc_cyc + 1;
                if (rel >= 1 && rel <= NUM_DIGITS) begin
                    chk("lut_idx_seq", ACC_W'(lut_idx), ACC_W'(q[0].upper[5*(rel-1) +: 5]));
                end else if (rel == NUM_DIGITS + 1) begin
                    chk("drain_lut_idx", ACC_W'(lut_idx), '0);
                    chk("drain_busy", ACC_W'(busy), ACC_W'(1));
                end
                if (done) begin
                    chk("done_latency", ACC_W'(rel), ACC_W'(NUM_DIGITS + 2));
                    chk("result", result, q[0].exp);
                    $display("txn: upper=0x%0h latency=%0d result_low=0x%0h", q[0].upper, rel, result[63:0]);
                    void'(q.pop_front());
                end else if (rel > NUM_DIGITS + 2) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_timeout: got no done by cycle %0d expected at %0d", rel, NUM_DIGITS + 2);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic [UP_W-1:0] up, input logic [DATA_W-1:0] lo);
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        upper_in = up;
        lower_in = lo;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL wait_idle: got %0d open transactions expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic set_identity();
        for (int j = 0; j < 32; j++) lut_tab[j] = DATA_W'(j);
    endtask

    initial begin
        logic [UP_W-1:0] up;
        int bc;
        bit seen;

        set_identity();
        #1;
        chk("reset_busy", ACC_W'(busy), '0);
        chk("reset_done", ACC_W'(done), '0);
        chk("reset_lut_idx", ACC_W'(lut_idx), '0);
        chk("reset_result", result, '0);
        #13 rst = 1'b0;

        // Case 1: all-zero digits still take the full latency.
        do_op('0, DATA_W'(5));
        bc = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (busy) bc++;
            if (done) seen = 1;
            else @(negedge clk);
        end
        chk("case1_busy_cycles", ACC_W'(bc), ACC_W'(NUM_DIGITS + 1));
        wait_idle(30);
        chk("case1_result_hold", result, ACC_W'(5));

        // Case 2: digits 1..8 on the identity table.
        for (int i = 0; i < NUM_DIGITS; i++) up[5*i +: 5] = 5'(i + 1);
        do_op(up, DATA_W'(100));
        wait_idle(30);
        chk("case2_result", result, ACC_W'(136));

        // Case 3: all-ones terms exercise the carry into the headroom bits.
        for (int j = 0; j < 32; j++) lut_tab[j] = '1;
        do_op('1, '1);
        wait_idle(30);
        chk("case3_upper_bits", ACC_W'(result[ACC_W-1:DATA_W]), ACC_W'(8));
        set_identity();

        // Case 4: start held 20 cycles, inputs changed mid-operation.
        for (int j = 0; j < 32; j++) lut_tab[j] = rand_word();
        @(negedge clk);
        upper_in = {$urandom, 8'($urandom)};
        lower_in = rand_word();
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                upper_in = {$urandom, 8'($urandom)};
                lower_in = rand_word();
            end
        end
        start = 1'b0;
        wait_idle(30);

        // Random operations, issued back-to-back, some with zero digits.
        for (int r = 0; r < 6; r++) begin
            up = {$urandom, 8'($urandom)};
            if (r % 2 == 1) up[5*($urandom_range(0, NUM_DIGITS-1)) +: 5] = 5'd0;
            do_op(up, rand_word());
        end
        wait_idle(40);

        // Case 5: asynchronous reset in cycle 4 of an operation.
        set_identity();
        do_op({$urandom, 8'($urandom)}, rand_word());
        @(negedge clk);
        @(negedge clk);
        #6;
        rst = 1'b1;
        #1;
        chk("rst_busy", ACC_W'(busy), '0);
        chk("rst_done", ACC_W'(done), '0);
        chk("rst_lut_idx", ACC_W'(lut_idx), '0);
        chk("rst_result", result, '0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) @(negedge clk);
        do_op({$urandom, 8'($urandom)}, rand_word());
        wait_idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
